// File: rtl/four_12_12_err_rx.sv
// Error-stream receiver: frames 32-bit error beats into FRAME_LEN-beat frames and buffers them
// in a DEPTH-entry FIFO toward back-propagation. Optional counters: FOUR_12_12_ERR_RX_STATS_EN.
module four_12_12_err_rx #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] stage_3_error,
  input  logic        stage_3_error_fst,
  input  logic        stage_3_error_vld,
  output logic        stage_3_error_rdy,
  output logic [31:0] bp_error,
  output logic        bp_error_fst,
  output logic        bp_error_lst,
  output logic        bp_error_vld,
  input  logic        bp_error_rdy,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  len_err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            rdy_en_q;

  logic [31:0]     buf_data [DEPTH];
  logic            buf_fst  [DEPTH];
  logic            buf_lst  [DEPTH];

  logic            in_xfer;
  logic            out_xfer;
  logic            store;
  logic            st_fst;
  logic            st_lst;

  // rdy_en_q keeps the input closed until the first clock edge after reset release
  assign stage_3_error_rdy = rdy_en_q && (count_q < CW'(DEPTH));
  assign bp_error_vld      = (count_q != '0);
  assign bp_error          = bp_error_vld ? buf_data[rd_ptr_q] : '0;
  assign bp_error_fst      = bp_error_vld ? buf_fst[rd_ptr_q]  : 1'b0;
  assign bp_error_lst      = bp_error_vld ? buf_lst[rd_ptr_q]  : 1'b0;
  assign frame_err         = frame_err_q;

  assign in_xfer  = stage_3_error_vld && stage_3_error_rdy;
  assign out_xfer = bp_error_vld && bp_error_rdy;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    store       = 1'b0;
    st_fst      = 1'b0;
    st_lst      = 1'b0;
    if (in_xfer) begin
      case (state_q)
        IDLE: begin
          if (stage_3_error_fst) begin
            store  = 1'b1;
            st_fst = 1'b1;
            if (FRAME_LEN == 1) begin
              st_lst = 1'b1;
            end else begin
              state_d = IN_FRAME;
              idx_d   = IW'(1);
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        IN_FRAME: begin
          store = 1'b1;
          if (stage_3_error_fst) begin
            // Short frame: the new fst beat restarts framing, the truncated frame never gets lst
            frame_err_d = 1'b1;
            st_fst      = 1'b1;
            idx_d       = IW'(1);
          end else if (idx_q == LAST_IDX) begin
            st_lst  = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = store    ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = out_xfer ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({store, out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      rdy_en_q    <= 1'b1;
    end
  end

  // Storage carries no reset; outputs are masked by vld so stale entries never show
  always_ff @(posedge clk) begin
    if (store) begin
      buf_data[wr_ptr_q] <= stage_3_error;
      buf_fst[wr_ptr_q]  <= st_fst;
      buf_lst[wr_ptr_q]  <= st_lst;
    end
  end

`ifdef FOUR_12_12_ERR_RX_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  len_err_cnt_q, len_err_cnt_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    len_err_cnt_d = len_err_cnt_q;
    if (store && st_lst) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (frame_err_d && (len_err_cnt_q != 8'hFF)) begin
      len_err_cnt_d = len_err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q   <= '0;
      len_err_cnt_q <= '0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      len_err_cnt_q <= len_err_cnt_d;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign len_err_cnt = len_err_cnt_q;
`else
  assign frame_cnt   = '0;
  assign len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_four_12_12_err_rx.sv
// Bench for four_12_12_err_rx: directed framing scenarios plus random traffic, all checked
// against a queue-based frame model; one line per output beat.
module tb_four_12_12_err_rx;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] stage_3_error = '0;
  logic        stage_3_error_fst = 1'b0;
  logic        stage_3_error_vld = 1'b0;
  logic        stage_3_error_rdy;
  logic [31:0] bp_error;
  logic        bp_error_fst;
  logic        bp_error_lst;
  logic        bp_error_vld;
  logic        bp_error_rdy = 1'b0;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [7:0]  len_err_cnt;

  four_12_12_err_rx #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk               (clk),
    .reset             (reset),
    .stage_3_error     (stage_3_error),
    .stage_3_error_fst (stage_3_error_fst),
    .stage_3_error_vld (stage_3_error_vld),
    .stage_3_error_rdy (stage_3_error_rdy),
    .bp_error          (bp_error),
    .bp_error_fst      (bp_error_fst),
    .bp_error_lst      (bp_error_lst),
    .bp_error_vld      (bp_error_vld),
    .bp_error_rdy      (bp_error_rdy),
    .frame_err         (frame_err),
    .frame_cnt         (frame_cnt),
    .len_err_cnt       (len_err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected buffer contents as {data, fst, lst}, plus frame progress
  logic [33:0] exp_q[$];
  bit m_in_frame;
  int m_pos;
  bit m_rdy_en;
  bit m_err_pending;
  int m_frames;
  int m_errs;
  int n_out;

  function automatic logic [15:0] exp_frame_cnt();
`ifdef FOUR_12_12_ERR_RX_STATS_EN
    return 16'(m_frames);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [7:0] exp_len_err();
`ifdef FOUR_12_12_ERR_RX_STATS_EN
    return 8'(m_errs);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_in_frame    = 1'b0;
    m_pos         = 0;
    m_rdy_en      = 1'b0;
    m_err_pending = 1'b0;
    m_frames      = 0;
    m_errs        = 0;
  endtask

  task automatic model_accept(input bit fst, input logic [31:0] d, output bit err);
    bit lst;
    err = 1'b0;
    if (fst) begin
      err = m_in_frame;
      lst = (FRAME_LEN == 1);
      exp_q.push_back({d, 1'b1, lst});
      if (lst) m_frames++;
      m_in_frame = !lst;
      m_pos = 1;
    end else if (!m_in_frame) begin
      err = 1'b1;
    end else begin
      lst = (m_pos == FRAME_LEN - 1);
      exp_q.push_back({d, 1'b0, lst});
      m_pos++;
      if (lst) begin
        m_in_frame = 1'b0;
        m_frames++;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_rdy;
    exp_rdy = m_rdy_en && (exp_q.size() < DEPTH);
    check_eq("rdy", 64'(stage_3_error_rdy), 64'(exp_rdy));
    check_eq("vld", 64'(bp_error_vld), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_eq("data", 64'(bp_error), 64'(exp_q[0][33:2]));
      check_eq("fst", 64'(bp_error_fst), 64'(exp_q[0][1]));
      check_eq("lst", 64'(bp_error_lst), 64'(exp_q[0][0]));
    end
    check_eq("frame_err", 64'(frame_err), 64'(m_err_pending));
    check_eq("frame_cnt", 64'(frame_cnt), 64'(exp_frame_cnt()));
    check_eq("len_err_cnt", 64'(len_err_cnt), 64'(exp_len_err()));
  endtask

  // One clock cycle: drive, check, advance the edge, update the model
  task automatic step(input bit vld, input bit fst, input logic [31:0] d, input bit brdy,
                      output bit acc);
    bit pop;
    bit err;
    logic [33:0] beat;
    stage_3_error_vld = vld;
    stage_3_error_fst = fst;
    stage_3_error     = d;
    bp_error_rdy      = brdy;
    #1;
    check_outputs();
    acc = vld && m_rdy_en && (exp_q.size() < DEPTH);
    pop = (exp_q.size() > 0) && brdy;
    @(posedge clk);
    #1;
    err = 1'b0;
    if (pop) begin
      beat = exp_q.pop_front();
      n_out++;
      $display("[%0t] out #%0d data=0x%08h fst=%0d lst=%0d", $time, n_out, beat[33:2], beat[1], beat[0]);
    end
    if (acc) model_accept(fst, d, err);
    m_err_pending = err;
    if (err && m_errs < 255) m_errs++;
    m_rdy_en = 1'b1;
  endtask

  task automatic send_beat(input bit fst, input logic [31:0] d, input bit brdy);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      step(1'b1, fst, d, brdy, acc);
      guard++;
    end
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit acc;
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || m_err_pending) && guard < 200) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, acc);
      guard++;
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);
    check_eq("drained_vld", 64'(bp_error_vld), 64'd0);
  endtask

  // Entered #1 after a rising edge; releases reset between edges
  task automatic do_reset();
    stage_3_error_vld = 1'b0;
    stage_3_error_fst = 1'b0;
    bp_error_rdy      = 1'b0;
    reset = 1'b0;
    #2;
    check_eq("rst_rdy", 64'(stage_3_error_rdy), 64'd0);
    check_eq("rst_vld", 64'(bp_error_vld), 64'd0);
    check_eq("rst_data", 64'(bp_error), 64'd0);
    check_eq("rst_fst_lst", 64'({bp_error_fst, bp_error_lst}), 64'd0);
    check_eq("rst_frame_err", 64'(frame_err), 64'd0);
    check_eq("rst_counters", 64'({frame_cnt, len_err_cnt}), 64'd0);
    @(posedge clk);
    #1;
    check_eq("rst_rdy_held", 64'(stage_3_error_rdy), 64'd0);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    model_reset();
    n_out = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single clean frame
    for (int i = 0; i < FRAME_LEN; i++) send_beat(i == 0, 32'h3F80_0000 + 32'(i), 1'b1);
    drain();
    check_eq("one_frame_cnt", 64'(frame_cnt), 64'(exp_frame_cnt()));

    // Backpressure: only DEPTH beats fit while downstream is stalled
    k = 0;
    for (int c = 0; c < 10; c++) begin
      step(k < 6, k == 0, 32'h4000_0000 + 32'(k), 1'b0, acc);
      if (acc) k++;
    end
    check_eq("stall_accepted", 64'(k), 64'(DEPTH));
    check_eq("stall_rdy_low", 64'(stage_3_error_rdy), 64'd0);
    while (k < 6) begin
      send_beat(1'b0, 32'h4000_0000 + 32'(k), 1'b1);
      k++;
    end
    drain();

    // Orphan beats after reset are dropped with a framing error each
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) send_beat(1'b0, 32'h5000_0000 + 32'(i), 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, acc);
    check_eq("orphan_len_err", 64'(len_err_cnt), 64'(exp_len_err()));
    check_eq("orphan_vld", 64'(bp_error_vld), 64'd0);

    // Short frame followed by a full frame
    do_reset();
    for (int i = 0; i < 5; i++) send_beat(i == 0, 32'h6000_0000 + 32'(i), 1'b1);
    for (int i = 0; i < FRAME_LEN; i++) send_beat(i == 0, 32'h6100_0000 + 32'(i), 1'b1);
    drain();
    check_eq("short_frame_cnt", 64'(frame_cnt), 64'(exp_frame_cnt()));
    check_eq("short_len_err", 64'(len_err_cnt), 64'(exp_len_err()));

    // Reset mid-frame with beats still buffered, then a clean frame
    for (int i = 0; i < 5; i++) send_beat(i == 0, 32'h7000_0000 + 32'(i), 1'b1);
    for (int i = 5; i < 7; i++) send_beat(1'b0, 32'h7000_0000 + 32'(i), 1'b0);
    check_eq("pre_reset_vld", 64'(bp_error_vld), 64'd1);
    do_reset();
    for (int i = 0; i < FRAME_LEN; i++) send_beat(i == 0, 32'h7100_0000 + 32'(i), 1'b1);
    drain();
    check_eq("post_reset_frame_cnt", 64'(frame_cnt), 64'(exp_frame_cnt()));

    // Random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom,
             $urandom_range(0, 2) != 0, acc);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
